// File: rtl/opll_bus_write_sequencer.sv
// opll_bus_write_sequencer
// Buffers {register, data} write requests in a small FIFO. Each request is
// replayed as a YM2413-style two-phase bus write: an address strobe (A0=0),
// then a data strobe (A0=1). After each strobe the chip's wait time is held
// off. The OPLL master clock equals clk, so the waits are counted in clk cycles.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_valid/o_ready     request handshake (o_ready = FIFO not full)
//   i_reg, i_data       OPLL register address and data
//   o_D, o_A0           registered bus data / address select
//   o_WR_n, o_CS_n      registered active-low write strobe / chip select
//   o_busy              sequencer active or FIFO non-empty
//   o_level             FIFO occupancy
module opll_bus_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_PULSE   = 4,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [7:0]                    i_reg,
  input  logic [7:0]                    i_data,
  output logic                          o_ready,
  output logic [7:0]                    o_D,
  output logic                          o_A0,
  output logic                          o_WR_n,
  output logic                          o_CS_n,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [7:0]    PULSE_M1 = 8'(WR_PULSE - 1);
  localparam logic [7:0]    AW_M1    = 8'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
  localparam logic [7:0]    DW_M1    = 8'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_WR,
    S_ADDR_HOLD,
    S_DATA_WR,
    S_DATA_HOLD
  } state_t;

  // FIFO
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop, w_empty;

  // Sequencer
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_cur_reg, r_cur_data;
  logic        r_busy;

  assign o_ready = (r_level != DEPTH_L);
  assign w_push  = i_valid && o_ready;
  assign w_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_busy  = r_busy;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_reg, i_data};
  end

  // Pointers wrap naturally: FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Counter holds (remaining cycles - 1) of the current phase; phase ends at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ADDR_WR;
          w_cnt_nxt   = PULSE_M1;
        end
      end
      S_ADDR_WR: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (ADDR_WAIT == 0) begin
          w_state_nxt = S_DATA_WR;
          w_cnt_nxt   = PULSE_M1;
        end else begin
          w_state_nxt = S_ADDR_HOLD;
          w_cnt_nxt   = AW_M1;
        end
      end
      S_ADDR_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = S_DATA_WR;
          w_cnt_nxt   = PULSE_M1;
        end
      end
      S_DATA_WR: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (DATA_WAIT != 0) begin
          w_state_nxt = S_DATA_HOLD;
          w_cnt_nxt   = DW_M1;
        end else if (!w_empty) begin
          // No data wait: chain straight into the next request.
          w_pop       = 1'b1;
          w_state_nxt = S_ADDR_WR;
          w_cnt_nxt   = PULSE_M1;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_DATA_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ADDR_WR;
          w_cnt_nxt   = PULSE_M1;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_cur_reg  <= 8'h00;
      r_cur_data <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) {r_cur_reg, r_cur_data} <= r_mem[r_rptr];
    end
  end

  // Bus outputs are registered from the current state, so they trail the
  // state by one cycle. o_busy is registered the same way so it drops only
  // once the final hold period has fully appeared on the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_D    <= 8'h00;
      o_A0   <= 1'b0;
      o_WR_n <= 1'b1;
      o_CS_n <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE) || !w_empty;
      o_WR_n <= 1'b1;
      o_CS_n <= 1'b1;
      case (r_state)
        S_ADDR_WR: begin
          o_D    <= r_cur_reg;
          o_A0   <= 1'b0;
          o_WR_n <= 1'b0;
          o_CS_n <= 1'b0;
        end
        S_DATA_WR: begin
          o_D    <= r_cur_data;
          o_A0   <= 1'b1;
          o_WR_n <= 1'b0;
          o_CS_n <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_opll_bus_write_sequencer.sv
// Bench for opll_bus_write_sequencer: one instance at default timing, one with
// WR_PULSE=1 and zero waits. Directed vectors with hand-computed expectations.
module tb_opll_bus_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v0, v1;
  logic [7:0] r0, d0, r1, d1;
  logic       rdy0, A00, WR0, CS0, busy0;
  logic       rdy1, A01, WR1, CS1, busy1;
  logic [7:0] D0, D1;
  logic [2:0] lvl0, lvl1;

  opll_bus_write_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_valid(v0), .i_reg(r0), .i_data(d0),
    .o_ready(rdy0), .o_D(D0), .o_A0(A00), .o_WR_n(WR0), .o_CS_n(CS0),
    .o_busy(busy0), .o_level(lvl0)
  );

  opll_bus_write_sequencer #(.WR_PULSE(1), .ADDR_WAIT(0), .DATA_WAIT(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .i_valid(v1), .i_reg(r1), .i_data(d1),
    .o_ready(rdy1), .o_D(D1), .o_A0(A01), .o_WR_n(WR1), .o_CS_n(CS1),
    .o_busy(busy1), .o_level(lvl1)
  );

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor on the default instance: records {A0,D} and cycle at each
  // WR_n fall, and counts D/A0 changes while WR_n stays low.
  logic [8:0] ev_q[$];
  int         ev_t[$];
  int         unstable = 0;
  logic       pwr = 1'b1;
  logic [7:0] pD  = 8'h00;
  logic       pA  = 1'b0;
  always @(negedge clk) begin
    if (pwr && !WR0) begin
      ev_q.push_back({A00, D0});
      ev_t.push_back(cyc);
    end
    if (!pwr && !WR0 && (D0 !== pD || A00 !== pA)) unstable <= unstable + 1;
    pwr <= WR0;
    pD  <= D0;
    pA  <= A00;
  end

  task automatic push(input bit sel, input logic [7:0] r, input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    if (sel) begin v1 = 1'b1; r1 = r; d1 = d; end
    else     begin v0 = 1'b1; r0 = r; d0 = d; end
    while (((sel ? rdy1 : rdy0) == 1'b0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) chk("push_tmo", w, 0);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_ev(input int n, input int budget);
    int w = 0;
    while (ev_q.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("ev_cnt", ev_q.size(), n);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy0 || busy1) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("idle", {busy0, busy1}, 0);
  endtask

  logic [7:0] br [6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
  logic [7:0] bd [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

  initial begin
    int t0, w, errs;
    logic exp_wr;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    r0 = 8'h00; d0 = 8'h00; r1 = 8'h00; d1 = 8'h00;

    // Reset with requests offered: nothing accepted, bus idle.
    @(negedge clk);
    v0 = 1'b1; r0 = 8'h55; d0 = 8'h66;
    v1 = 1'b1; r1 = 8'h55; d1 = 8'h66;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr",   WR0, 1);
    chk("rst_cs",   CS0, 1);
    chk("rst_d",    D0, 8'h00);
    chk("rst_a0",   A00, 0);
    chk("rst_lvl",  lvl0, 0);
    chk("rst_rdy",  rdy0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_lvlf", lvl1, 0);
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_noacc", lvl0, 0);
    chk("rst_noev",  ev_q.size(), 0);

    // Single write, default timing.
    push(0, 8'h10, 8'hAB);
    t0 = cyc;
    w  = 0;
    while (WR0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("lat", cyc - t0, 2);
    errs = 0;
    for (int k = 0; k < 104; k++) begin
      exp_wr = !(k < 4 || (k >= 16 && k < 20));
      if (WR0 !== exp_wr || CS0 !== exp_wr) errs++;
      if (k < 4 && (D0 !== 8'h10 || A00 !== 1'b0)) errs++;
      if (k >= 16 && k < 20 && (D0 !== 8'hAB || A00 !== 1'b1)) errs++;
      if (busy0 !== 1'b1) errs++;
      @(negedge clk);
    end
    chk("single_pat",  errs, 0);
    chk("single_busy", busy0, 0);
    chk("single_hold_d", D0, 8'hAB);
    chk("single_hold_a", A00, 1);

    // Burst of 6 into a 4-deep FIFO.
    wait_idle();
    ev_q.delete(); ev_t.delete();
    for (int i = 0; i < 5; i++) push(0, br[i], bd[i]);
    @(negedge clk);
    chk("full_rdy", rdy0, 0);
    chk("full_lvl", lvl0, 4);
    push(0, br[5], bd[5]);
    wait_ev(12, 900);
    if (ev_q.size() >= 12) begin
      for (int i = 0; i < 6; i++) begin
        chk("burst_reg",  ev_q[2*i],   {1'b0, br[i]});
        chk("burst_data", ev_q[2*i+1], {1'b1, bd[i]});
      end
      for (int i = 1; i < 6; i++) chk("burst_gap", ev_t[2*i] - ev_t[2*i-2], 104);
    end

    // Zero-wait, single-cycle-pulse instance: strobes back to back.
    wait_idle();
    push(1, 8'h31, 8'h41);
    push(1, 8'h32, 8'h42);
    w = 0;
    while (WR1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("fast_wr", WR1, 0);
      chk("fast_a0", A01, k % 2);
      chk("fast_d",  D1, (k == 0) ? 8'h31 : (k == 1) ? 8'h41 : (k == 2) ? 8'h32 : 8'h42);
      @(negedge clk);
    end
    chk("fast_end", WR1, 1);

    // Push and pop in the same cycle at level 1.
    wait_idle();
    ev_q.delete(); ev_t.delete();
    push(0, 8'h51, 8'h61);
    push(0, 8'h52, 8'h62);
    chk("pp_lvl", lvl0, 1);
    wait_ev(4, 400);
    if (ev_q.size() >= 4) begin
      chk("pp_0", ev_q[0], {1'b0, 8'h51});
      chk("pp_1", ev_q[1], {1'b1, 8'h61});
      chk("pp_2", ev_q[2], {1'b0, 8'h52});
      chk("pp_3", ev_q[3], {1'b1, 8'h62});
    end

    // Reset during the data strobe with two entries still queued.
    wait_idle();
    ev_q.delete(); ev_t.delete();
    push(0, 8'h71, 8'h81);
    push(0, 8'h72, 8'h82);
    push(0, 8'h73, 8'h83);
    wait_ev(2, 100);
    chk("mid_pre_wr",  WR0, 0);
    chk("mid_pre_a0",  A00, 1);
    chk("mid_pre_lvl", lvl0, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_wr",   WR0, 1);
    chk("mid_cs",   CS0, 1);
    chk("mid_lvl",  lvl0, 0);
    chk("mid_busy", busy0, 0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("mid_quiet", ev_q.size(), 2);
    chk("mid_idle",  busy0, 0);

    chk("d_stable", unstable, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
